// File: rtl/in_stream_arbiter.sv
// in_stream_arbiter: shares one USB CDC IN byte stream between N_SRC byte
// producers. Round-robin arbitration with burst locking. A grant is released
// after MAX_BURST transfers or after IDLE_CYCLES consecutive cycles with the
// owner's valid low. No bytes are buffered; the datapath is a mux driven by
// the registered grant.
//
// Handshake: every port pair (src_valid_i/src_ready_o, in_valid_o/in_ready_i)
// is strict valid/ready. A byte moves on a rising edge where both are high.
// A producer holds data stable with valid high until that edge. Valid never
// waits on ready. Ready is combinational from in_ready_i and the registered
// grant only.
module in_stream_arbiter #(
    parameter int N_SRC       = 2,
    parameter int MAX_BURST   = 8,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [8*N_SRC-1:0]   src_data_i,
    input  logic [N_SRC-1:0]     src_valid_i,
    output logic [N_SRC-1:0]     src_ready_o,
    output logic [7:0]           in_data_o,
    output logic                 in_valid_o,
    input  logic                 in_ready_i,
    output logic [N_SRC-1:0]     grant_o,
    output logic                 busy_o
);

    localparam int IDX_W = (N_SRC > 2) ? 2 : 1;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [7:0] IDLE_LIM  = 8'(IDLE_CYCLES);

    logic               state_q, state_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         burst_q, burst_d;
    logic [7:0]         idle_q, idle_d;

    logic               sel_valid;
    logic               xfer;
    logic               release_grant;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_SRC-1:0]   pick_oh;

    // busy_o is the FSM state itself, so it doubles as the state observation point
    assign busy_o     = (state_q == ST_LOCKED);
    assign grant_o    = grant_q;
    assign in_valid_o = sel_valid & busy_o;
    assign xfer       = in_valid_o & in_ready_i;

    // Mux the owner's byte, valid and ready through the one-hot registered grant
    always_comb begin
        in_data_o   = 8'h00;
        sel_valid   = 1'b0;
        src_ready_o = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant_q[k]) begin
                in_data_o      = src_data_i[8*k +: 8];
                sel_valid      = src_valid_i[k];
                src_ready_o[k] = in_ready_i & busy_o;
            end
        end
    end

    // Round-robin scan: first requesting source after the pointer wins, so the
    // most recently released source has the lowest priority
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        for (int off = 1; off <= N_SRC; off++) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (!pick_found && (k == ((int'(ptr_q) + off) % N_SRC)) && src_valid_i[k]) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(k);
                    pick_oh[k] = 1'b1;
                end
            end
        end
    end

    // Next-state: lock on a request from IDLE, release on burst limit or idle timeout
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        burst_d       = burst_q;
        idle_d        = idle_q;
        release_grant = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                state_d = ST_LOCKED;
                grant_d = pick_oh;
                gidx_d  = pick_idx;
                burst_d = 8'h00;
                idle_d  = 8'h00;
            end
        end else begin
            if (xfer) begin
                // a transfer implies valid high, so the idle timer cannot also fire
                burst_d = burst_q + 8'd1;
                idle_d  = 8'h00;
                if (burst_q + 8'd1 == BURST_LIM) begin
                    release_grant = 1'b1;
                end
            end else if (sel_valid) begin
                // stalled by the sink: not idle, keep waiting indefinitely
                idle_d = 8'h00;
            end else begin
                idle_d = idle_q + 8'd1;
                if (idle_q + 8'd1 == IDLE_LIM) begin
                    release_grant = 1'b1;
                end
            end

            if (release_grant) begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = gidx_q;
                burst_d = 8'h00;
                idle_d  = 8'h00;
            end
        end
    end

    // State registers; pointer resets to the last source so source 0 wins first
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IDX_W'(N_SRC - 1);
            burst_q <= 8'h00;
            idle_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
        end
    end

endmodule

// File: tb/tb_in_stream_arbiter.sv
// Bench for in_stream_arbiter: a 2-source instance checked every cycle
// against a transaction-level model plus per-source scoreboards, and a
// 4-source MAX_BURST=1 instance checked from a vector table.
module tb_in_stream_arbiter;

    localparam int MB = 8;
    localparam int IC = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    // two-source instance
    logic [15:0] d2_data   = '0;
    logic [1:0]  d2_valid  = '0;
    logic [1:0]  d2_sready;
    logic [7:0]  d2_in_data;
    logic        d2_in_valid;
    logic        d2_in_ready = 1'b0;
    logic [1:0]  d2_grant;
    logic        d2_busy;

    // four-source single-byte-burst instance
    logic [31:0] d4_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic [3:0]  d4_valid  = '0;
    logic [3:0]  d4_sready;
    logic [7:0]  d4_in_data;
    logic        d4_in_valid;
    logic        d4_in_ready = 1'b0;
    logic [3:0]  d4_grant;
    logic        d4_busy;

    in_stream_arbiter #(.N_SRC(2), .MAX_BURST(MB), .IDLE_CYCLES(IC)) u_dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .src_data_i  (d2_data),
        .src_valid_i (d2_valid),
        .src_ready_o (d2_sready),
        .in_data_o   (d2_in_data),
        .in_valid_o  (d2_in_valid),
        .in_ready_i  (d2_in_ready),
        .grant_o     (d2_grant),
        .busy_o      (d2_busy)
    );

    in_stream_arbiter #(.N_SRC(4), .MAX_BURST(1), .IDLE_CYCLES(IC)) u_dut4 (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .src_data_i  (d4_data),
        .src_valid_i (d4_valid),
        .src_ready_o (d4_sready),
        .in_data_o   (d4_in_data),
        .in_valid_o  (d4_in_valid),
        .in_ready_i  (d4_in_ready),
        .grant_o     (d4_grant),
        .busy_o      (d4_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: current owner (-1 = nobody), last released owner, counts
    int m_owner;
    int m_ptr;
    int m_burst;
    int m_idle;

    // sources: pending bytes, held-valid flag, presentation probability
    logic [7:0] src_q [2][$];
    logic [7:0] exp_q [2][$];
    logic       hold  [2];
    int         pct   [2];
    int         rdy_pct;

    // per-scenario observation logs
    logic [1:0] obs_grant [256];
    logic       obs_busy  [256];
    logic       obs_xfer  [256];
    int         lcyc;
    int         run_cnt;
    logic       prev_busy;
    int         bursts_q [$];
    logic [1:0] lock_log [$];

    typedef struct {
        logic [3:0] valid;
        logic       ready;
        logic [3:0] exp_grant;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec4_t;

    vec4_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 1;
        m_burst = 0;
        m_idle  = 0;
    endtask

    // one clock of the arbitration rules, applied to the inputs seen this cycle
    task automatic model_step(input logic [1:0] v, input logic r);
        if (m_owner < 0) begin
            for (int i = 1; i <= 2; i++) begin
                int c;
                c = (m_ptr + i) % 2;
                if (m_owner < 0 && v[c[0]]) begin
                    m_owner = c;
                    m_burst = 0;
                    m_idle  = 0;
                end
            end
        end else if (v[m_owner[0]] && r) begin
            m_burst++;
            m_idle = 0;
            if (m_burst == MB) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end else if (v[m_owner[0]]) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == IC) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] b);
        src_q[k].push_back(b);
        exp_q[k].push_back(b);
    endtask

    // drive one cycle of the 2-source instance, compare, scoreboard, advance
    task automatic step();
        logic [1:0] eg;
        logic [1:0] er;
        logic       ev;
        logic       eb;
        logic [7:0] ed;
        logic       did_xfer;
        for (int k = 0; k < 2; k++) begin
            if (!hold[k] && src_q[k].size() > 0 && int'($urandom_range(99)) < pct[k]) hold[k] = 1'b1;
            d2_valid[k]          = hold[k];
            d2_data[8*k +: 8]    = hold[k] ? src_q[k][0] : 8'h00;
        end
        d2_in_ready = (int'($urandom_range(99)) < rdy_pct);
        #4;
        eg = 2'b00; er = 2'b00; ev = 1'b0; eb = 1'b0; ed = 8'h00;
        if (m_owner >= 0) begin
            eb = 1'b1;
            eg = m_owner[0] ? 2'b10 : 2'b01;
            ev = d2_valid[m_owner[0]];
            ed = m_owner[0] ? d2_data[15:8] : d2_data[7:0];
            er = eg & {2{d2_in_ready}};
        end
        check($sformatf("outs cyc%0d {grant,busy,valid,sready,data}", lcyc),
              {50'd0, d2_grant, d2_busy, d2_in_valid, d2_sready, d2_in_data},
              {50'd0, eg, eb, ev, er, ed});
        did_xfer = d2_in_valid && d2_in_ready;
        if (did_xfer) begin
            if (m_owner < 0 || exp_q[m_owner[0]].size() == 0)
                check("sb_unexpected_xfer", {63'd0, d2_in_valid}, 64'd0);
            else
                check($sformatf("sb_data src%0d", m_owner), {56'd0, d2_in_data}, {56'd0, exp_q[m_owner[0]].pop_front()});
            run_cnt++;
        end
        for (int k = 0; k < 2; k++) begin
            if (d2_valid[k] && d2_sready[k]) begin
                void'(src_q[k].pop_front());
                hold[k] = 1'b0;
            end
        end
        if (lcyc < 256) begin
            obs_grant[lcyc] = d2_grant;
            obs_busy[lcyc]  = d2_busy;
            obs_xfer[lcyc]  = did_xfer;
        end
        lcyc++;
        if (d2_busy && !prev_busy) lock_log.push_back(d2_grant);
        if (!d2_busy && prev_busy) begin
            bursts_q.push_back(run_cnt);
            run_cnt = 0;
        end
        prev_busy = d2_busy;
        model_step(d2_valid, d2_in_ready);
        @(posedge clk);
        #1;
    endtask

    // assert reset away from a clock edge and check outputs fall at once
    task automatic do_reset(input bit keep_src);
        rstn = 1'b0;
        #1;
        check("rst_in_valid", {63'd0, d2_in_valid}, 64'd0);
        check("rst_grant",    {62'd0, d2_grant},    64'd0);
        check("rst_busy",     {63'd0, d2_busy},     64'd0);
        check("rst_sready",   {62'd0, d2_sready},   64'd0);
        check("rst_in_data",  {56'd0, d2_in_data},  64'd0);
        if (!keep_src) begin
            for (int k = 0; k < 2; k++) begin
                src_q[k].delete();
                exp_q[k].delete();
                hold[k] = 1'b0;
            end
            d2_valid = '0;
            d2_data  = '0;
        end
        model_reset();
        prev_busy = 1'b0;
        run_cnt   = 0;
        lcyc      = 0;
        bursts_q.delete();
        lock_log.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        int bad;
        hold[0] = 1'b0; hold[1] = 1'b0;
        pct[0] = 100;  pct[1] = 100;
        rdy_pct = 100;
        model_reset();

        // grant walks 0..3 with one IDLE cycle between single-byte grants
        tbl[0]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00};
        tbl[1]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0};
        tbl[2]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00};
        tbl[3]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 8'hA1};
        tbl[4]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00};
        tbl[5]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 8'hA2};
        tbl[6]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00};
        tbl[7]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 8'hA3};
        tbl[8]  = '{4'hF, 1'b1, 4'b0000, 1'b0, 8'h00};
        tbl[9]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 8'hA0};
        tbl[10] = '{4'hF, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[11] = '{4'hF, 1'b0, 4'b0010, 1'b1, 8'hA1};

        do_reset(1'b0);

        // single source, 20 bytes: bursts 8, 8, 4
        for (int i = 0; i < 20; i++) push_byte(0, 8'(i));
        for (int i = 0; i < 32; i++) step();
        check("single_nbursts", 64'(bursts_q.size()), 64'd3);
        if (bursts_q.size() == 3) begin
            check("single_burst0", 64'(bursts_q[0]), 64'd8);
            check("single_burst1", 64'(bursts_q[1]), 64'd8);
            check("single_burst2", 64'(bursts_q[2]), 64'd4);
        end
        for (int i = 0; i < lock_log.size(); i++) check($sformatf("single_grant%0d", i), {62'd0, lock_log[i]}, 64'd1);
        check("single_gap_busy9", {63'd0, obs_busy[9]}, 64'd0);
        check("single_xfer10",    {63'd0, obs_xfer[10]}, 64'd1);
        check("single_drained",   64'(exp_q[0].size()), 64'd0);

        // contention: strict alternation, eight bytes each
        do_reset(1'b0);
        for (int i = 0; i < 24; i++) begin
            push_byte(0, 8'(i));
            push_byte(1, 8'(8'h80 + i));
        end
        for (int i = 0; i < 60; i++) step();
        check("cont_nlocks", 64'(lock_log.size()), 64'd6);
        for (int i = 0; i < lock_log.size(); i++)
            check($sformatf("cont_grant%0d", i), {62'd0, lock_log[i]}, (i % 2 == 0) ? 64'd1 : 64'd2);
        for (int i = 0; i < bursts_q.size(); i++) check($sformatf("cont_burst%0d", i), 64'(bursts_q[i]), 64'd8);
        check("cont_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

        // idle release: src0 valid falls at cycle 4, release after 4 idle cycles
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) push_byte(0, 8'(8'h30 + i));
        for (int i = 0; i < 4; i++) step();
        push_byte(1, 8'h40);
        push_byte(1, 8'h41);
        for (int i = 0; i < 12; i++) step();
        check("idle_busy7",  {63'd0, obs_busy[7]},  64'd1);
        check("idle_grant7", {62'd0, obs_grant[7]}, 64'd1);
        check("idle_busy8",  {63'd0, obs_busy[8]},  64'd0);
        check("idle_grant9", {62'd0, obs_grant[9]}, 64'd2);
        check("idle_xfer9",  {63'd0, obs_xfer[9]},  64'd1);
        check("idle_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

        // backpressure: 50 stalled cycles, grant held, then 0xA5 moves
        do_reset(1'b0);
        push_byte(1, 8'hA5);
        rdy_pct = 0;
        for (int i = 0; i < 51; i++) step();
        bad = 0;
        for (int i = 1; i <= 50; i++)
            if (!(obs_busy[i] && obs_grant[i] == 2'b10 && !obs_xfer[i])) bad++;
        check("stall_hold_bad_cycles", 64'(bad), 64'd0);
        rdy_pct = 100;
        step();
        check("stall_release_xfer", {63'd0, obs_xfer[51]}, 64'd1);
        for (int i = 0; i < 6; i++) step();
        check("stall_drained", 64'(exp_q[1].size()), 64'd0);

        // async reset after 5 of 8 bytes; src0 wins first again afterwards
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) push_byte(0, 8'(8'h50 + i));
        for (int i = 0; i < 6; i++) step();
        check("ar_sent5", 64'(exp_q[0].size()), 64'd3);
        push_byte(1, 8'h60);
        push_byte(1, 8'h61);
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) step();
        check("ar_first_grant", {62'd0, obs_grant[1]}, 64'd1);
        check("ar_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

        // four sources, single-byte bursts, from the vector table
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            d4_valid    = tbl[i].valid;
            d4_in_ready = tbl[i].ready;
            #4;
            check($sformatf("t4_grant[%0d]", i),    {60'd0, d4_grant},    {60'd0, tbl[i].exp_grant});
            check($sformatf("t4_in_valid[%0d]", i), {63'd0, d4_in_valid}, {63'd0, tbl[i].exp_valid});
            check($sformatf("t4_in_data[%0d]", i),  {56'd0, d4_in_data},  {56'd0, tbl[i].exp_data});
            check($sformatf("t4_sready[%0d]", i),   {60'd0, d4_sready},   {60'd0, tbl[i].exp_grant & {4{tbl[i].ready}}});
            @(posedge clk);
            #1;
        end
        d4_valid    = '0;
        d4_in_ready = 1'b0;

        // randomized traffic against the model
        do_reset(1'b0);
        for (int r = 0; r < 3; r++) begin
            pct[0]  = int'($urandom_range(100, 20));
            pct[1]  = int'($urandom_range(100, 20));
            rdy_pct = int'($urandom_range(100, 30));
            for (int i = 0; i < 600; i++) begin
                for (int k = 0; k < 2; k++)
                    if (src_q[k].size() < 3) push_byte(k, 8'($urandom));
                step();
            end
        end
        pct[0] = 100; pct[1] = 100; rdy_pct = 100;
        for (int i = 0; i < 400 && (src_q[0].size() + src_q[1].size()) > 0; i++) step();
        check("rand_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
